// File: rtl/div_param_if.sv
// Request/result bundle between the issuing execute stage (master) and div_param (slave).
interface div_param_if #(
    parameter int unsigned WIDTH = 32
);
    logic             signed_div_i;
    logic [WIDTH-1:0] opdata1_i;
    logic [WIDTH-1:0] opdata2_i;
    logic             start_i;
    logic             annul_i;
    logic [WIDTH-1:0] quotient_o;
    logic [WIDTH-1:0] remainder_o;
    logic             ready_o;
    logic             div_by_zero_o;
    logic             busy;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  quotient_o, remainder_o, ready_o, div_by_zero_o, busy
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output quotient_o, remainder_o, ready_o, div_by_zero_o, busy
    );
endinterface

// File: rtl/div_param.sv
// Multi-cycle restoring divider, one quotient bit per cycle, signed/unsigned, div-by-zero result.
// Define DIV_EARLY_OUT_EN to skip the dividend's leading zeros (shorter latency, same results).
module div_param #(
    parameter int unsigned WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    div_param_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_FREE, S_BYZERO, S_ON, S_END} state_t;

    state_t           r_state,   w_state;
    logic [CNT_W-1:0] r_cnt,     w_cnt;
    logic [WIDTH-1:0] r_dq,      w_dq;
    logic [WIDTH-1:0] r_divisor, w_divisor;
    logic [WIDTH-1:0] r_rem,     w_rem;
    logic             r_neg_q,   w_neg_q;
    logic             r_neg_r,   w_neg_r;
    logic [WIDTH-1:0] r_quot,    w_quot;
    logic [WIDTH-1:0] r_remd,    w_remd;
    logic             r_ready,   w_ready;
    logic             r_dbz,     w_dbz;

    logic             w_op1_neg;
    logic             w_op2_neg;
    logic [WIDTH-1:0] w_abs1;
    logic [WIDTH-1:0] w_abs2;
    logic [CNT_W-1:0] w_lz;
    logic [WIDTH-1:0] w_dq_init;
    logic [WIDTH+1:0] w_trial;
    logic             w_borrow;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;

    assign w_op1_neg = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
    assign w_op2_neg = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
    assign w_abs1    = w_op1_neg ? (~bus.opdata1_i + WIDTH'(1)) : bus.opdata1_i;
    assign w_abs2    = w_op2_neg ? (~bus.opdata2_i + WIDTH'(1)) : bus.opdata2_i;

`ifdef DIV_EARLY_OUT_EN
    // Leading-zero count of |op1|; the highest set bit wins because it is visited last.
    always_comb begin
        w_lz = CNT_W'(WIDTH);
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (w_abs1[i]) w_lz = CNT_W'(WIDTH - 1 - i);
        end
    end
    assign w_dq_init = w_abs1 << w_lz;
`else
    assign w_lz      = '0;
    assign w_dq_init = w_abs1;
`endif

    // Extra top bit of the trial acts as the borrow out of the (WIDTH+1)-bit subtraction.
    assign w_trial  = {1'b0, r_rem, r_dq[WIDTH-1]} - {2'b00, r_divisor};
    assign w_borrow = w_trial[WIDTH+1];
    assign w_q_fix  = r_neg_q ? (~r_dq  + WIDTH'(1)) : r_dq;
    assign w_r_fix  = r_neg_r ? (~r_rem + WIDTH'(1)) : r_rem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_FREE;
            r_cnt     <= '0;
            r_dq      <= '0;
            r_divisor <= '0;
            r_rem     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_quot    <= '0;
            r_remd    <= '0;
            r_ready   <= 1'b0;
            r_dbz     <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_dq      <= w_dq;
            r_divisor <= w_divisor;
            r_rem     <= w_rem;
            r_neg_q   <= w_neg_q;
            r_neg_r   <= w_neg_r;
            r_quot    <= w_quot;
            r_remd    <= w_remd;
            r_ready   <= w_ready;
            r_dbz     <= w_dbz;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_dq      = r_dq;
        w_divisor = r_divisor;
        w_rem     = r_rem;
        w_neg_q   = r_neg_q;
        w_neg_r   = r_neg_r;
        w_quot    = r_quot;
        w_remd    = r_remd;
        w_ready   = r_ready;
        w_dbz     = r_dbz;

        case (r_state)
            S_FREE: begin
                if (bus.start_i && !bus.annul_i) begin
                    if (bus.opdata2_i == '0) begin
                        w_state = S_BYZERO;
                    end else begin
                        w_divisor = w_abs2;
                        w_dq      = w_dq_init;
                        w_rem     = '0;
                        w_cnt     = w_lz;
                        w_neg_q   = bus.signed_div_i & (bus.opdata1_i[WIDTH-1] ^ bus.opdata2_i[WIDTH-1]);
                        w_neg_r   = w_op1_neg;
                        w_state   = S_ON;
                    end
                end
            end
            S_BYZERO: begin
                if (bus.annul_i) begin
                    w_state = S_FREE;
                end else begin
                    w_quot  = '1;
                    w_remd  = bus.opdata1_i;
                    w_ready = 1'b1;
                    w_dbz   = 1'b1;
                    w_state = S_END;
                end
            end
            S_ON: begin
                if (bus.annul_i) begin
                    w_state = S_FREE;
                end else if (r_cnt == CNT_W'(WIDTH)) begin
                    w_quot  = w_q_fix;
                    w_remd  = w_r_fix;
                    w_ready = 1'b1;
                    w_state = S_END;
                end else begin
                    w_rem = w_borrow ? {r_rem[WIDTH-2:0], r_dq[WIDTH-1]} : WIDTH'(w_trial);
                    w_dq  = {r_dq[WIDTH-2:0], ~w_borrow};
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            S_END: begin
                if (!bus.start_i) begin
                    w_ready = 1'b0;
                    w_dbz   = 1'b0;
                    w_state = S_FREE;
                end
            end
            default: w_state = S_FREE;
        endcase
    end

    assign bus.quotient_o    = r_quot;
    assign bus.remainder_o   = r_remd;
    assign bus.ready_o       = r_ready;
    assign bus.div_by_zero_o = r_dbz;
    assign bus.busy          = bus.start_i & ~r_ready;
endmodule
